// File: rtl/mem_pkg.sv
// Shared types and helpers for the processor-side memory responders.
// The address check is kept here so a future instruction-memory responder reuses it.
package mem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } dmem_state_t;

    // Flags misaligned word accesses and byte addresses beyond the stored words.
    // The compare is one bit wider so 4*depth cannot overflow.
    function automatic logic addr_err(input logic [WORD_W-1:0] addr, input int unsigned depth);
        logic [WORD_W:0] limit;
        limit = {1'b0, 32'(depth)} << 2;
        return (addr[1:0] != 2'b00) || ({1'b0, addr} >= limit);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store port between the datapath (master) and the data-memory responder (slave).
interface dmem_responder_if;

    logic                       req_valid;
    logic                       req_ready;
    logic                       req_we;
    logic [mem_pkg::WORD_W-1:0] req_addr;
    logic [mem_pkg::WORD_W-1:0] req_wdata;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [mem_pkg::WORD_W-1:0] rsp_rdata;
    logic                       rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_array.sv
// Word storage for the data memory: synchronous write, combinational read.
// Contents are deliberately left unreset so data survives a controller reset.
module dmem_array
    import mem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Wait-stated data-memory responder: accepts one word request, waits WAIT_CYCLES,
// then commits the store or samples the load and holds the response until taken.
//
// state | meaning
// IDLE  | ready for a request; req_ready=1
// WAIT  | request latched, wait counter running down to zero
// RESP  | response presented on rsp_*, held until rsp_ready
module dmem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    dmem_state_t       state;
    dmem_state_t       state_nxt;
    logic [3:0]        cnt;

    logic              lat_we;
    logic [WORD_W-1:0] lat_addr;
    logic [WORD_W-1:0] lat_wdata;

    logic              cur_we;
    logic [WORD_W-1:0] cur_addr;
    logic [WORD_W-1:0] cur_wdata;
    logic              cur_err;

    logic              accept;
    logic              enter_resp;
    logic              leave_resp;
    logic              mem_we;
    logic [WORD_W-1:0] mem_rdata;

    logic              rdy;
    logic              vld;
    logic [WORD_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rdy = 1'b0;
        vld = 1'b0;
        case (state)
            IDLE:    rdy = 1'b1;
            RESP:    vld = 1'b1;
            default: begin
                rdy = 1'b0;
                vld = 1'b0;
            end
        endcase
    end

    assign accept     = rdy && bus.req_valid;
    assign enter_resp = (state != RESP) && (state_nxt == RESP);
    assign leave_resp = (state == RESP) && (state_nxt != RESP);

    // With zero wait states the commit edge is the accept edge, so the
    // request must come straight from the port rather than the latch.
    assign cur_we    = (state == IDLE) ? bus.req_we    : lat_we;
    assign cur_addr  = (state == IDLE) ? bus.req_addr  : lat_addr;
    assign cur_wdata = (state == IDLE) ? bus.req_wdata : lat_wdata;
    assign cur_err   = addr_err(cur_addr, DEPTH);

    assign mem_we = enter_resp && cur_we && !cur_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (accept) begin
            lat_we    <= bus.req_we;
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= 4'd0;
        end else if (accept) begin
            cnt <= CNT_INIT;
        end else if ((state == WAIT) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else if (enter_resp) begin
            rsp_rdata_q <= (cur_we || cur_err) ? '0 : mem_rdata;
            rsp_err_q   <= cur_err;
        end else if (leave_resp) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .idx   (cur_addr[AW+1:2]),
        .wdata (cur_wdata),
        .rdata (mem_rdata)
    );

    assign bus.req_ready = rdy;
    assign bus.rsp_valid = vld;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states, one with none.
module tb_dmem_responder;
    import mem_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   acc_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder_if bus2();
    dmem_responder_if bus0();

    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input bit z, input logic v, input logic we,
                           input logic [31:0] a, input logic [31:0] d);
        if (z) begin
            bus0.req_valid = v; bus0.req_we = we; bus0.req_addr = a; bus0.req_wdata = d;
        end else begin
            bus2.req_valid = v; bus2.req_we = we; bus2.req_addr = a; bus2.req_wdata = d;
        end
    endtask

    task automatic set_rspr(input bit z, input logic r);
        if (z) bus0.rsp_ready = r;
        else   bus2.rsp_ready = r;
    endtask

    function automatic logic r_valid(input bit z);
        return z ? bus0.rsp_valid : bus2.rsp_valid;
    endfunction
    function automatic logic r_ready(input bit z);
        return z ? bus0.req_ready : bus2.req_ready;
    endfunction
    function automatic logic [31:0] r_rdata(input bit z);
        return z ? bus0.rsp_rdata : bus2.rsp_rdata;
    endfunction
    function automatic logic r_err(input bit z);
        return z ? bus0.rsp_err : bus2.rsp_err;
    endfunction

    // One full transaction; noise drives an altered request during the wait.
    task automatic xact(input bit z, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input bit noise, input string tag);
        int lat;
        @(negedge clk);
        chk(32'(r_ready(z)), 32'd1, {tag, "_ready_in"});
        set_req(z, 1'b1, we, addr, wdata);
        set_rspr(z, 1'b1);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if (noise) set_req(z, 1'b1, ~we, addr ^ 32'h8, ~wdata);
        else       set_req(z, 1'b0, 1'b0, 32'h0, 32'h0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!r_valid(z) && lat < 20);
        set_req(z, 1'b0, 1'b0, 32'h0, 32'h0);
        chk(32'(lat), z ? 32'd1 : 32'd3, {tag, "_latency"});
        chk(r_rdata(z), exp_rdata, {tag, "_rdata"});
        chk(32'(r_err(z)), 32'(exp_err), {tag, "_err"});
        @(posedge clk);
        #1;
        chk(32'(r_valid(z)), 32'd0, {tag, "_valid_out"});
        chk(32'(r_ready(z)), 32'd1, {tag, "_ready_out"});
        chk(r_rdata(z), 32'h0, {tag, "_rdata_clr"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int lat;
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        set_rspr(1'b0, 1'b0);
        set_rspr(1'b1, 1'b0);
        #2;
        chk(32'(bus2.req_ready), 32'd1, "rst_ready");
        chk(32'(bus2.rsp_valid), 32'd0, "rst_valid");
        chk(bus2.rsp_rdata, 32'h0, "rst_rdata");
        chk(32'(bus2.rsp_err), 32'd0, "rst_err");
        chk(32'(bus0.req_ready), 32'd1, "rst0_ready");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // store/load round trip with two wait states
        xact(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, "t1_st");
        xact(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, "t1_ld");

        // alignment and range errors
        xact(1'b0, 1'b1, 32'hFC, 32'h12345678, 32'h0, 1'b0, 1'b0, "t2_st_fc");
        xact(1'b0, 1'b1, 32'h0, 32'h00C0FFEE, 32'h0, 1'b0, 1'b0, "t2_st_0");
        xact(1'b0, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1'b0, "t2_ld_mis");
        xact(1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 1'b0, "t2_ld_oor");
        xact(1'b0, 1'b1, 32'h102, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, "t2_st_102");
        xact(1'b0, 1'b1, 32'h100, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, "t2_st_100");
        xact(1'b0, 1'b0, 32'hFC, 32'h0, 32'h12345678, 1'b0, 1'b0, "t2_ld_fc");
        xact(1'b0, 1'b0, 32'h0, 32'h0, 32'h00C0FFEE, 1'b0, 1'b0, "t2_ld_0");

        // backpressure on the response
        @(negedge clk);
        set_req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
        set_rspr(1'b0, 1'b0);
        @(posedge clk);
        #1;
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus2.rsp_valid && lat < 20);
        chk(32'(lat), 32'd3, "t3_latency");
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk(32'(bus2.rsp_valid), 32'd1, "t3_hold_valid");
            chk(bus2.rsp_rdata, 32'hDEADBEEF, "t3_hold_rdata");
            chk(32'(bus2.rsp_err), 32'd0, "t3_hold_err");
            chk(32'(bus2.req_ready), 32'd0, "t3_hold_ready");
            set_req(1'b0, 1'b1, 1'b1, 32'h10, 32'hBAD0BAD0);
        end
        @(negedge clk);
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_rspr(1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk(32'(bus2.req_ready), 32'd1, "t3_release_ready");
        chk(32'(bus2.rsp_valid), 32'd0, "t3_release_valid");
        xact(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, "t3_ld_after");

        // zero wait states, back-to-back store then load
        xact(1'b1, 1'b1, 32'h0, 32'h1, 32'h0, 1'b0, 1'b0, "t4_st");
        a = acc_cyc;
        xact(1'b1, 1'b0, 32'h0, 32'h0, 32'h1, 1'b0, 1'b0, "t4_ld");
        chk(32'(acc_cyc - a), 32'd2, "t4_period");

        // reset in the middle of a store's wait
        xact(1'b0, 1'b1, 32'h20, 32'h0, 32'h0, 1'b0, 1'b0, "t5_pre");
        @(negedge clk);
        set_req(1'b0, 1'b1, 1'b1, 32'h20, 32'hA5A5A5A5);
        set_rspr(1'b0, 1'b1);
        @(posedge clk);
        #1;
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk(32'(bus2.req_ready), 32'd0, "t5_in_wait");
        #2;
        reset = 1'b0;
        #1;
        chk(32'(bus2.req_ready), 32'd1, "t5_async_ready");
        chk(32'(bus2.rsp_valid), 32'd0, "t5_async_valid");
        chk(bus2.rsp_rdata, 32'h0, "t5_async_rdata");
        chk(32'(bus2.rsp_err), 32'd0, "t5_async_err");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        xact(1'b0, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 1'b0, "t5_ld_20");
        xact(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, "t5_ld_10");
        xact(1'b0, 1'b0, 32'hFC, 32'h0, 32'h12345678, 1'b0, 1'b0, "t5_ld_fc");

        // request inputs changing after acceptance
        xact(1'b0, 1'b1, 32'h2C, 32'h11111111, 32'h0, 1'b0, 1'b0, "t6_st_2c");
        xact(1'b0, 1'b1, 32'h24, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1, "t6_st_noise");
        xact(1'b0, 1'b0, 32'h24, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1, "t6_ld_noise");
        xact(1'b0, 1'b0, 32'h2C, 32'h0, 32'h11111111, 1'b0, 1'b0, "t6_ld_2c");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
